// File: rtl/mdu.sv
// Multiply/divide unit for the execute stage. Holds the architectural HI/LO
// registers, runs mult/multu/div/divu over a fixed number of busy cycles and
// writes both results together on the completion edge.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Pending,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic          is_md_op;
  logic [63:0]   prod;
  logic          div_signed;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, b_safe;
  logic [31:0]   q_mag, r_mag;
  logic [31:0]   quot, rem;

  assign is_md_op = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
  assign Busy     = (state_q != ST_IDLE);
  assign Pending  = Busy | (Start & is_md_op);
  assign HI       = hi_q;
  assign LO       = lo_q;

  // Result datapath, evaluated from the operands latched at start so the
  // live A/B inputs are free to change during the busy period. Division works
  // on magnitudes, which also makes 0x80000000 / -1 fall out as 0x80000000.
  always_comb begin
    if (op_q == OP_MULT) begin
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    end else begin
      prod = {32'd0, a_q} * {32'd0, b_q};
    end
    div_signed = (op_q == OP_DIV);
    a_neg      = div_signed & a_q[31];
    b_neg      = div_signed & b_q[31];
    a_mag      = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag      = b_neg ? (~b_q + 32'd1) : b_q;
    b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  // Next-state logic: accept requests only in IDLE, count down while busy,
  // and commit HI/LO on the last busy cycle (skipped for divide by zero).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (MDOp == OP_MULT || MDOp == OP_MULTU) begin
            state_d = ST_MUL;
            cnt_d   = CW'(MULT_CYCLES);
            op_d    = MDOp;
            a_d     = A;
            b_d     = B;
          end else if (MDOp == OP_DIV || MDOp == OP_DIVU) begin
            state_d = ST_DIV;
            cnt_d   = CW'(DIV_CYCLES);
            op_d    = MDOp;
            a_d     = A;
            b_d     = B;
          end else if (MDOp == OP_MTHI) begin
            hi_d = A;
          end else if (MDOp == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset clears everything and drops any result in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the pipelined MIPS core. It sits in the execute stage, takes operands read from the GRF, and runs `mult`/`multu`/`div`/`divu` over several cycles. It holds the architectural HI/LO registers, whose values return through the pipeline to the GRF write port for `mfhi`/`mflo`. It also reports a busy status that the hazard unit uses to stall dependent instructions.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu` (≥1).
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu` (≥1).

Ports:
- `Clk`, input, 1: single clock; everything updates on the rising edge.
- `Reset`, input, 1: synchronous, active-high.
- `Start`, input, 1: one-cycle request qualifier for `MDOp`.
- `MDOp`, input, 3: operation code.
  - 0: none.
  - 1: MULT. 2: MULTU. 3: DIV. 4: DIVU.
  - 5: MTHI. 6: MTLO.
  - 7: reserved; treated as none.
- `A`, input, 32: rs operand (GRF RD1 after forwarding).
- `B`, input, 32: rt operand (GRF RD2 after forwarding).
- `Busy`, output, 1: registered; 1 while a multiply or divide is in flight.
- `Pending`, output, 1: combinational; equals `Busy | (Start & MDOp in 1..4)`. The hazard unit stalls `mfhi`/`mflo`/`md` ops on this signal.
- `HI`, output, 32: architectural HI register.
- `LO`, output, 32: architectural LO register.

## Operation
- **State machine:** IDLE, MUL, DIV.
  - The counter `cnt` is wide enough for `max(MULT_CYCLES, DIV_CYCLES)`.
- **Start in IDLE with MDOp 1–4:**
  - Latch `A`, `B` and the op.
  - Load `cnt` with the op's latency.
  - Go to MUL or DIV.
  - After this edge, the inputs `A`/`B` may change freely.
- **Countdown in MUL/DIV:**
  - `cnt` decrements every cycle.
  - When `cnt` reaches 1, the next edge writes HI/LO and returns to IDLE.
- **Start in IDLE with MDOp 5 or 6:**
  - HI (or LO) takes `A` at this edge.
  - No busy period.
- **Start while Busy (any op):** ignored. This is a protocol violation, because the pipeline must stall on `Pending`. The bench flags it as an error and checks that state is unaffected.
- **MULT:** {HI,LO} = signed(A) × signed(B), full 64 bits.
- **MULTU:** {HI,LO} = unsigned(A) × unsigned(B), full 64 bits.
- **DIV:**
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- **DIVU:** LO = A / B, HI = A % B, unsigned.
- **Divide by zero (B = 0 for DIV/DIVU):**
  - The full busy period still runs.
  - HI and LO are left unchanged at completion.
- **Write timing:** HI/LO change only at a completion edge or an MTHI/MTLO edge. Neither output ever shows an intermediate value.
- **Reset:** HI=0, LO=0, Busy=0, state IDLE, `cnt`=0. Reset takes priority over Start and aborts any operation in flight; the pending result is discarded.

## Timing
- **Multiply/divide request:** Start with MDOp 1–4 is sampled at the edge ending cycle t.
  - Busy=1 in cycles t+1 … t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - New HI/LO and Busy=0 are visible in cycle t+N+1.
- **Back-to-back ops:** a new Start is accepted in cycle t+N+1, the first cycle with Busy=0.
- **Pending:** is 1 in cycle t, during the Start cycle itself, with no registered delay.
- **MTHI/MTLO:** sampled at the edge ending t; the new HI/LO is visible in t+1.
- **Reading HI/LO:** outputs are registers and are stable for the whole cycle. Reading them is combinational with zero latency, for the `mfhi`/`mflo` path to GRF WD.
- **Reset in cycle t:** in t+1 every output is 0, whatever the state was in t.

## Test plan
- **MULT:** A=0xFFFFFFFE (−2), B=0x00000003 → after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA. Busy was high for exactly 5 cycles.
- **MULTU:** A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- **DIV:** A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU with the same operands gives LO=0x7FFFFFFC, HI=1.
- **DIV by zero:** MTHI 0x11111111, MTLO 0x22222222, then DIV with B=0 → Busy runs 10 cycles, then HI/LO still hold 0x11111111/0x22222222.
- **Ignored Start and operand latching:** start MULT with A=3, B=4, then on cycle t+2 assert Start with MDOp=6 and A=0xDEAD, changing A/B → LO=12 and HI=0 at completion; the MTLO is ignored.
- **Reset mid-operation:** Reset at the third busy cycle of a DIV → next cycle Busy=0, HI=LO=0. A following MULT 2×3 completes normally with LO=6.
